paged_buffer: RTL
=================

PAGED_BUFFER -- requirements
Module: paged_buffer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- RAM_WIDTH, 18: data width.
- RAM_DEPTH, 16: entries per page, power of two, at least 2.
- PAGES, 4: page count, power of two, at least 2.
- RAM_PERFORMANCE, "HIGH_PERFORMANCE": "HIGH_PERFORMANCE" gives 2-cycle read latency; "LOW_LATENCY" gives 1-cycle read latency.
REQ-002 Derived widths SHALL be AW = clog2(RAM_DEPTH), PW = clog2(PAGES) and NW = AW+1.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock for all logic.
- rst_n, in, 1: synchronous, active-low reset.
- wr_en, in, 1: append wr_data to the open write page.
- wr_data, in, RAM_WIDTH: write data.
- wr_commit, in, 1: close the open write page and hand it to the read side.
- wr_ready, out, 1: a write page is open.
- wr_page, out, PW: index of the open write page.
- wr_count, out, NW: entries written to the open page so far.
- wr_ovf, out, 1: sticky flag, a write was dropped.
- rd_avail, out, 1: at least one committed page is waiting.
- rd_page, out, PW: oldest committed page.
- rd_nent, out, NW: entry count of rd_page.
- rd_en, in, 1: read request.
- rd_addr, in, AW: entry offset within rd_page.
- rd_done, in, 1: release rd_page back to the free pool.
- doutb, out, RAM_WIDTH: read data.
- dout_valid, out, 1: doutb holds the data for an accepted read.
- pages_used, out, PW+1: number of committed, unreleased pages.

Function
REQ-004 Storage SHALL be one block RAM of PAGES*RAM_DEPTH words, addressed as page*RAM_DEPTH + offset.
REQ-005 Pages SHALL circulate in ring order: the write pointer wp and the read pointer rp each advance modulo PAGES.
REQ-006 wr_ready SHALL be 1 when pages_used < PAGES, and wr_page SHALL equal wp.
REQ-007 A write SHALL be accepted when wr_en=1, wr_ready=1 and wr_count < RAM_DEPTH; it stores wr_data at offset wr_count and increments wr_count on the next edge.
REQ-008 wr_en while wr_ready=0, or while wr_count = RAM_DEPTH, SHALL drop the data, leave the RAM and counters unchanged, and set wr_ovf=1 until reset.
REQ-009 A commit SHALL be accepted when wr_commit=1 and wr_ready=1. On the next edge it shall:
- latch the page's entry count into nent[wp];
- advance wp;
- clear wr_count to 0;
- increment pages_used.
REQ-010 When wr_en and wr_commit are both accepted in the same cycle, the write SHALL land first; the latched count includes it (wr_count+1, saturating at RAM_DEPTH).
REQ-011 Committing a page with wr_count=0 SHALL be legal and produce a committed page with rd_nent=0.
REQ-012 wr_commit while wr_ready=0 SHALL be ignored and SHALL NOT set wr_ovf.
REQ-013 rd_avail SHALL equal (pages_used != 0); rd_page SHALL equal rp; rd_nent SHALL equal nent[rp].
REQ-014 A read SHALL be accepted when rd_en=1 and rd_avail=1, using RAM address rp*RAM_DEPTH + rd_addr; rd_en while rd_avail=0 SHALL be ignored.
REQ-015 Read latency:
- LOW_LATENCY: doutb and dout_valid SHALL update 1 cycle after acceptance.
- HIGH_PERFORMANCE: through an output register, 2 cycles after acceptance.
- Cycles with no accepted read SHALL give dout_valid=0 and doutb holding its last value.
REQ-016 Reads with rd_addr >= rd_nent SHALL be accepted and return stale RAM contents, with no flag raised.
REQ-017 rd_done with rd_avail=1 SHALL advance rp and decrement pages_used on the next edge; rd_done with rd_avail=0 SHALL be ignored.
REQ-018 Reads already accepted before rd_done SHALL still complete with their original data and dout_valid.
REQ-019 When a commit and an rd_done are accepted in the same cycle, pages_used SHALL stay unchanged while both wp and rp advance.
REQ-020 A commit into the last free page SHALL drive wr_ready=0 from the next cycle. An rd_done in that same cycle SHALL keep wr_ready=1.
REQ-021 The RAM SHALL allow a write and a read in the same cycle. A read of the page currently open for writing is impossible by construction, so no read-during-write bypass is required.

Reset
REQ-022 While rst_n=0 at a rising clk edge, the block SHALL set:
- wp, rp, wr_count and pages_used to 0;
- all nent[] entries to 0;
- wr_ovf, dout_valid and rd_avail to 0, and wr_ready to 1;
- doutb and the pipeline registers to 0.
REQ-023 Reset SHALL NOT clear RAM contents.
REQ-024 Reads and writes in flight when reset is applied SHALL be discarded, with no dout_valid after reset.
REQ-025 Inputs SHALL be ignored on any cycle where rst_n=0.

Verification
REQ-026 Basic write/read (defaults): write 5 words 0x00A..0x00E, commit, then read offsets 0..4 on consecutive cycles -> rd_avail=1, rd_nent=5, rd_page=0; doutb returns 0x00A..0x00E with dout_valid 2 cycles after each read.
REQ-027 Page-full overflow: write 17 words to one page -> wr_count saturates at 16, wr_ovf=1 after the 17th write, and the RAM holds only the first 16 words.
REQ-028 Back-pressure: commit 4 pages with no rd_done -> wr_ready=0 and pages_used=4; a further wr_en sets wr_ovf; a single rd_done -> wr_ready=1, pages_used=3, rd_page=1.
REQ-029 Simultaneous events:
- wr_en with wr_commit on wr_count=3 -> rd_nent=4.
- commit with rd_done at pages_used=2 -> pages_used stays 2, and wp and rp both advance.
- empty commit -> rd_nent=0.
REQ-030 Reset mid-operation: assert rst_n=0 for 1 cycle one cycle after a read is accepted, with 2 pages committed -> no dout_valid, pages_used=0, wr_ready=1, wr_ovf=0, doutb=0.
REQ-031 LOW_LATENCY mode with PAGES=2 and RAM_DEPTH=8: repeat REQ-026 -> data arrives 1 cycle after each read; ring wrap over 5 commit/release pairs gives rd_page sequence 0,1,0,1,0.

Source files
------------

// File: rtl/paged_buffer.sv
// Paged ping-pong style buffer: a ring of PAGES pages in one block RAM.
// The writer fills and commits pages in order; the reader reads and releases them in the same order.
module paged_buffer #(
  parameter int    RAM_WIDTH       = 18,
  parameter int    RAM_DEPTH       = 16,
  parameter int    PAGES           = 4,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  localparam int   AW              = $clog2(RAM_DEPTH),
  localparam int   PW              = $clog2(PAGES),
  localparam int   NW              = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [RAM_WIDTH-1:0] wr_data,
  input  logic                 wr_commit,
  output logic                 wr_ready,
  output logic [PW-1:0]        wr_page,
  output logic [NW-1:0]        wr_count,
  output logic                 wr_ovf,
  output logic                 rd_avail,
  output logic [PW-1:0]        rd_page,
  output logic [NW-1:0]        rd_nent,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 rd_done,
  output logic [RAM_WIDTH-1:0] doutb,
  output logic                 dout_valid,
  output logic [PW:0]          pages_used
);
  localparam int STAGES = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;

  logic [RAM_WIDTH-1:0]       r_mem [PAGES*RAM_DEPTH];
  logic [PW-1:0]              r_wp, r_rp;
  logic [NW-1:0]              r_wcnt;
  logic [PW:0]                r_used;
  logic [PAGES-1:0][NW-1:0]   r_nent;
  logic                       r_ovf;
  logic [RAM_WIDTH-1:0]       r_ramq;
  logic [STAGES:1]            r_vld_pipe;

  logic w_ready, w_full, w_wr_acc, w_cm_acc, w_rd_acc, w_done_acc, w_avail;
  logic [NW-1:0] w_cm_cnt;

  assign w_ready    = (r_used != (PW+1)'(PAGES));
  assign w_avail    = (r_used != '0);
  assign w_full     = (r_wcnt == NW'(RAM_DEPTH));
  // rst_n gates the RAM port too, since the RAM itself has no reset
  assign w_wr_acc   = rst_n & wr_en & w_ready & ~w_full;
  assign w_cm_acc   = wr_commit & w_ready;
  assign w_rd_acc   = rst_n & rd_en & w_avail;
  assign w_done_acc = rd_done & w_avail;
  assign w_cm_cnt   = w_wr_acc ? r_wcnt + 1'b1 : r_wcnt;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[{r_wp, r_wcnt[AW-1:0]}] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_wcnt <= '0;
      r_used <= '0;
      r_nent <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_cm_acc) begin
        r_nent[r_wp] <= w_cm_cnt;
        r_wp         <= r_wp + 1'b1;
        r_wcnt       <= '0;
      end else if (w_wr_acc) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (wr_en && !(w_ready && !w_full)) r_ovf <= 1'b1;
      if (w_done_acc) r_rp <= r_rp + 1'b1;
      // simultaneous commit and release cancel out
      if (w_cm_acc && !w_done_acc)      r_used <= r_used + 1'b1;
      else if (!w_cm_acc && w_done_acc) r_used <= r_used - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ramq     <= '0;
      r_vld_pipe <= '0;
    end else begin
      if (w_rd_acc) r_ramq <= r_mem[{r_rp, rd_addr}];
      r_vld_pipe[1] <= w_rd_acc;
      for (int s = 2; s <= STAGES; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
    end
  end

  generate
    if (STAGES == 2) begin : g_hp
      logic [RAM_WIDTH-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (!rst_n)             r_dout <= '0;
        else if (r_vld_pipe[1]) r_dout <= r_ramq;
      end
      assign doutb = r_dout;
    end else begin : g_ll
      assign doutb = r_ramq;
    end
  endgenerate

  assign dout_valid = r_vld_pipe[STAGES];
  assign wr_ready   = w_ready;
  assign wr_page    = r_wp;
  assign wr_count   = r_wcnt;
  assign wr_ovf     = r_ovf;
  assign rd_avail   = w_avail;
  assign rd_page    = r_rp;
  assign rd_nent    = r_nent[r_rp];
  assign pages_used = r_used;
endmodule
